// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_n
// Desc     : Registered N-channel, WIDTH-bit multiplexer with manual select
//            and auto-scan (programmable dwell, wrap pulse, range error).
//            Optional channel-skip mask enabled by MUX_SCAN_MASK_EN.
// Revision : 1.0
// ============================================================================
module mux_scan_n #(
    parameter int WIDTH = 1,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N),
    parameter int DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   din,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]         ch_mask,
`endif
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [SELW-1:0]      sel_out,
    output logic                 wrap,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    localparam logic [SELW:0]   c_N          = (SELW+1)'(N);
    localparam logic [SELW-1:0] c_LAST       = SELW'(N-1);
    localparam logic [15:0]     c_DWELL_LAST = 16'(DWELL-1);

    state_t           r_state;
    logic [SELW-1:0]  r_ptr;
    logic [15:0]      r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic [SELW-1:0]  r_sel;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_ch [N];
    logic             w_sel_ok;
    logic             w_adv;
    logic             w_any;
    logic [SELW-1:0]  w_first;
    logic [SELW-1:0]  w_next;
    logic             w_next_wrap;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign w_ch[k] = din[k*WIDTH +: WIDTH];
    end

    assign w_sel_ok = ({1'b0, sel_in} < c_N);
    assign w_adv    = (r_cnt == c_DWELL_LAST);

`ifdef MUX_SCAN_MASK_EN
    logic [SELW-1:0] w_next_hi;
    logic            w_found_hi;

    // Descending search leaves the lowest qualifying index in each result.
    always_comb begin
        w_first    = '0;
        w_any      = 1'b0;
        w_next_hi  = '0;
        w_found_hi = 1'b0;
        for (int k = N-1; k >= 0; k--) begin
            if (!ch_mask[k]) begin
                w_first = SELW'(k);
                w_any   = 1'b1;
                if (k > int'(r_ptr)) begin
                    w_next_hi  = SELW'(k);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_next      = w_found_hi ? w_next_hi : w_first;
        w_next_wrap = !w_found_hi;
    end
`else
    assign w_any       = 1'b1;
    assign w_first     = '0;
    assign w_next      = (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
    assign w_next_wrap = (r_ptr == c_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
            end else if (!mode) begin
                r_state <= S_MANUAL;
                if (w_sel_ok) begin
                    r_q     <= w_ch[sel_in];
                    r_sel   <= sel_in;
                    r_valid <= 1'b1;
                end else begin
                    r_err   <= 1'b1;
                end
            end else begin
                r_state <= S_SCAN;
                // Nothing to scan: outputs, pointer and dwell all hold.
                if (!w_any) begin
                    r_valid <= 1'b0;
                end else if (r_state != S_SCAN) begin
                    r_ptr   <= w_first;
                    r_cnt   <= '0;
                    r_q     <= w_ch[w_first];
                    r_sel   <= w_first;
                    r_valid <= 1'b1;
                end else if (w_adv) begin
                    r_ptr   <= w_next;
                    r_cnt   <= '0;
                    r_q     <= w_ch[w_next];
                    r_sel   <= w_next;
                    r_valid <= 1'b1;
                    r_wrap  <= w_next_wrap;
                end else begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_q     <= w_ch[r_ptr];
                    r_sel   <= r_ptr;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_valid;
    assign sel_out = r_sel;
    assign wrap    = r_wrap;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// Testbench for mux_scan_n: three instances (N=8/W=1/D=1, N=6/W=4/D=2,
// N=4/W=8/D=3) checked against a list-and-arithmetic reference model.
module tb_mux_scan_n;

    logic clk = 1'b0;
    logic rst, en, mode;
    always #5 clk = ~clk;

    logic [7:0]  din8;  logic [2:0] sel8; logic [0:0] q8; logic v8; logic [2:0] so8; logic w8; logic e8;
    logic [23:0] din6;  logic [2:0] sel6; logic [3:0] q6; logic v6; logic [2:0] so6; logic w6; logic e6;
    logic [31:0] din4;  logic [1:0] sel4; logic [7:0] q4; logic v4; logic [1:0] so4; logic w4; logic e4;
    logic [7:0]  mask8 = 8'h00;
    logic [5:0]  mask6 = 6'h00;
    logic [3:0]  mask4 = 4'h0;

    int checks = 0;
    int errors = 0;

    mux_scan_n #(.WIDTH(1), .N(8), .DWELL(1)) u8 (
        .clk(clk), .rst(rst), .din(din8), .en(en), .mode(mode), .sel_in(sel8),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(mask8),
`endif
        .q(q8), .q_valid(v8), .sel_out(so8), .wrap(w8), .err(e8));

    mux_scan_n #(.WIDTH(4), .N(6), .DWELL(2)) u6 (
        .clk(clk), .rst(rst), .din(din6), .en(en), .mode(mode), .sel_in(sel6),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(mask6),
`endif
        .q(q6), .q_valid(v6), .sel_out(so6), .wrap(w6), .err(e6));

    mux_scan_n #(.WIDTH(8), .N(4), .DWELL(3)) u4 (
        .clk(clk), .rst(rst), .din(din4), .en(en), .mode(mode), .sel_in(sel4),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(mask4),
`endif
        .q(q4), .q_valid(v4), .sel_out(so4), .wrap(w4), .err(e4));

    // Channel visited t cycles after scan entry: walk the unmasked list.
    function automatic int ref_idx(int n, int d, logic [7:0] msk, int t);
        int lst[$];
        for (int i = 0; i < n; i++) if (!msk[i]) lst.push_back(i);
        if (lst.size() == 0) return -1;
        return lst[(t / d) % lst.size()];
    endfunction

    function automatic bit ref_wrap(int n, int d, logic [7:0] msk, int t);
        int cnt = 0;
        for (int i = 0; i < n; i++) if (!msk[i]) cnt++;
        return (cnt > 0) && (t > 0) && ((t % (cnt * d)) == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 1'b1;
        sel8 = 0; sel6 = 0; sel4 = 0;
        din8 = 8'hFF; din6 = 24'hFFFFFF; din4 = 32'hFFFF_FFFF;
        repeat (9) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (q8 !== 1'b0 || v8 !== 1'b0 || so8 !== 3'd0 || w8 !== 1'b0 || e8 !== 1'b0) begin
            errors++; $display("FAIL reset_u8: got q=%0h v=%0b sel=%0d wrap=%0b err=%0b, expected all 0", q8, v8, so8, w8, e8); end
        checks++; if (q6 !== 4'd0 || v6 !== 1'b0 || so6 !== 3'd0 || w6 !== 1'b0 || e6 !== 1'b0) begin
            errors++; $display("FAIL reset_u6: got q=%0h v=%0b sel=%0d wrap=%0b err=%0b, expected all 0", q6, v6, so6, w6, e6); end
        checks++; if (q4 !== 8'd0 || v4 !== 1'b0 || so4 !== 2'd0 || w4 !== 1'b0 || e4 !== 1'b0) begin
            errors++; $display("FAIL reset_u4: got q=%0h v=%0b sel=%0d wrap=%0b err=%0b, expected all 0", q4, v4, so4, w4, e4); end
        #3 rst = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_manual_sweep();
        int exp_tab[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
        en = 1'b1; mode = 1'b0; din8 = 8'b0110_1101;
        for (int s = 0; s < 8; s++) begin
            sel8 = 3'(s);
            tick();
            checks++; if (q8 !== 1'(exp_tab[s]) || so8 !== 3'(s) || v8 !== 1'b1) begin
                errors++; $display("FAIL manual_sweep sel=%0d: got q=%0b sel_out=%0d v=%0b, expected q=%0d sel_out=%0d v=1", s, q8, so8, v8, exp_tab[s], s); end
        end
    endtask

    task automatic test_manual_random();
        logic [3:0] held6;
        logic [2:0] held6s;
        en = 1'b1; mode = 1'b0; sel6 = 3'd0; din6 = 24'($urandom);
        tick();
        held6 = din6[3:0]; held6s = 3'd0;
        for (int i = 0; i < 24; i++) begin
            din8 = 8'($urandom); din6 = 24'($urandom); din4 = $urandom;
            sel8 = 3'($urandom_range(0, 7)); sel6 = 3'($urandom_range(0, 7)); sel4 = 2'($urandom_range(0, 3));
            tick();
            checks++; if (q8 !== din8[sel8] || so8 !== sel8) begin
                errors++; $display("FAIL manual_u8: got q=%0b sel=%0d, expected q=%0b sel=%0d", q8, so8, din8[sel8], sel8); end
            checks++; if (q4 !== din4[sel4*8 +: 8] || so4 !== sel4 || v4 !== 1'b1) begin
                errors++; $display("FAIL manual_u4: got q=%0h sel=%0d v=%0b, expected q=%0h sel=%0d v=1", q4, so4, v4, din4[sel4*8 +: 8], sel4); end
            if (sel6 < 3'd6) begin held6 = din6[sel6*4 +: 4]; held6s = sel6; end
            checks++; if (q6 !== held6 || so6 !== held6s || e6 !== (sel6 >= 3'd6) || v6 !== (sel6 < 3'd6)) begin
                errors++; $display("FAIL manual_u6 sel_in=%0d: got q=%0h sel=%0d err=%0b v=%0b, expected q=%0h sel=%0d err=%0b v=%0b",
                                   sel6, q6, so6, e6, v6, held6, held6s, sel6 >= 3'd6, sel6 < 3'd6); end
        end
    endtask

    task automatic test_range_error();
        logic [3:0] prev;
        en = 1'b1; mode = 1'b0; din6 = 24'h654321; sel6 = 3'd2;
        tick();
        prev = 4'h3;
        din6 = 24'hABCDEF; sel6 = 3'd6;
        tick();
        checks++; if (e6 !== 1'b1 || v6 !== 1'b0 || q6 !== prev || so6 !== 3'd2) begin
            errors++; $display("FAIL range_err: got err=%0b v=%0b q=%0h sel=%0d, expected err=1 v=0 q=%0h sel=2", e6, v6, q6, so6, prev); end
        sel6 = 3'd2;
        tick();
        checks++; if (e6 !== 1'b0 || v6 !== 1'b1 || q6 !== 4'hD || so6 !== 3'd2) begin
            errors++; $display("FAIL range_clear: got err=%0b v=%0b q=%0h sel=%0d, expected err=0 v=1 q=d sel=2", e6, v6, q6, so6); end
    endtask

    task automatic test_scan(input bit fixed);
        int i8, i6, i4;
        bit ew8, ew6, ew4;
        en = 1'b1; mode = 1'b0; sel8 = 0; sel6 = 0; sel4 = 0;
        tick();
        mode = 1'b1;
        for (int t = 0; t < 30; t++) begin
            din8 = 8'($urandom); din6 = 24'($urandom);
            din4 = fixed ? 32'hDDCC_BBAA : $urandom;
            tick();
            i8 = ref_idx(8, 1, mask8, t); ew8 = ref_wrap(8, 1, mask8, t);
            i6 = ref_idx(6, 2, 8'h00, t); ew6 = ref_wrap(6, 2, 8'h00, t);
            i4 = ref_idx(4, 3, 8'h00, t); ew4 = ref_wrap(4, 3, 8'h00, t);
            checks++; if (q8 !== din8[i8] || so8 !== i8[2:0] || v8 !== 1'b1) begin
                errors++; $display("FAIL scan_u8 t=%0d: got q=%0b sel=%0d v=%0b, expected q=%0b sel=%0d v=1", t, q8, so8, v8, din8[i8], i8); end
            checks++; if (w8 !== ew8) begin
                errors++; $display("FAIL scan_wrap_u8 t=%0d: got %0b expected %0b", t, w8, ew8); end
            checks++; if (q6 !== din6[i6*4 +: 4] || so6 !== i6[2:0] || v6 !== 1'b1) begin
                errors++; $display("FAIL scan_u6 t=%0d: got q=%0h sel=%0d v=%0b, expected q=%0h sel=%0d v=1", t, q6, so6, v6, din6[i6*4 +: 4], i6); end
            checks++; if (w6 !== ew6) begin
                errors++; $display("FAIL scan_wrap_u6 t=%0d: got %0b expected %0b", t, w6, ew6); end
            checks++; if (q4 !== din4[i4*8 +: 8] || so4 !== i4[1:0] || v4 !== 1'b1) begin
                errors++; $display("FAIL scan_u4 t=%0d: got q=%0h sel=%0d v=%0b, expected q=%0h sel=%0d v=1", t, q4, so4, v4, din4[i4*8 +: 8], i4); end
            checks++; if (w4 !== ew4) begin
                errors++; $display("FAIL scan_wrap_u4 t=%0d: got %0b expected %0b", t, w4, ew4); end
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] e;
        en = 1'b1; mode = 1'b0; sel4 = 2'd0; din4 = 32'hDDCC_BBAA;
        tick();
        mode = 1'b1;
        repeat (7) tick();
        checks++; if (so4 !== 2'd2 || q4 !== 8'hCC) begin
            errors++; $display("FAIL switch_pre: got sel=%0d q=%0h, expected sel=2 q=cc", so4, q4); end
        mode = 1'b0; sel4 = 2'd1;
        tick();
        checks++; if (q4 !== 8'hBB || so4 !== 2'd1 || v4 !== 1'b1) begin
            errors++; $display("FAIL switch_manual: got q=%0h sel=%0d v=%0b, expected q=bb sel=1 v=1", q4, so4, v4); end
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            e = (k < 3) ? 8'hAA : 8'hBB;
            checks++; if (q4 !== e) begin
                errors++; $display("FAIL switch_reentry k=%0d: got q=%0h expected %0h", k, q4, e); end
        end
    endtask

    task automatic test_en_low();
        en = 1'b1; mode = 1'b0; din4 = 32'hDDCC_BBAA;
        tick();
        mode = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (q4 !== 8'hBB || v4 !== 1'b0 || so4 !== 2'd1 || w4 !== 1'b0 || e4 !== 1'b0) begin
                errors++; $display("FAIL en_low k=%0d: got q=%0h v=%0b sel=%0d wrap=%0b err=%0b, expected q=bb v=0 sel=1 wrap=0 err=0", k, q4, v4, so4, w4, e4); end
        end
        en = 1'b1;
        tick();
        checks++; if (q4 !== 8'hAA || so4 !== 2'd0 || v4 !== 1'b1) begin
            errors++; $display("FAIL en_restart: got q=%0h sel=%0d v=%0b, expected q=aa sel=0 v=1", q4, so4, v4); end
        repeat (3) tick();
        checks++; if (q4 !== 8'hBB || so4 !== 2'd1) begin
            errors++; $display("FAIL en_restart_dwell: got q=%0h sel=%0d, expected q=bb sel=1", q4, so4); end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        int i8;
        logic ehold;
        en = 1'b1; mode = 1'b0; sel8 = 3'd0; mask8 = 8'hAA;
        tick();
        mode = 1'b1;
        ehold = 1'b0;
        for (int t = 0; t < 12; t++) begin
            din8 = 8'($urandom);
            tick();
            i8 = ref_idx(8, 1, mask8, t);
            ehold = din8[i8];
            checks++; if (q8 !== din8[i8] || so8 !== i8[2:0] || w8 !== ref_wrap(8, 1, mask8, t)) begin
                errors++; $display("FAIL mask_scan t=%0d: got q=%0b sel=%0d wrap=%0b, expected q=%0b sel=%0d wrap=%0b",
                                   t, q8, so8, w8, din8[i8], i8, ref_wrap(8, 1, mask8, t)); end
        end
        mask8 = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            din8 = 8'($urandom);
            tick();
            checks++; if (q8 !== ehold || v8 !== 1'b0 || w8 !== 1'b0) begin
                errors++; $display("FAIL mask_all k=%0d: got q=%0b v=%0b wrap=%0b, expected q=%0b v=0 wrap=0", k, q8, v8, w8, ehold); end
        end
        mode = 1'b0; sel8 = 3'd3; din8 = 8'b0000_1000;
        tick();
        checks++; if (q8 !== 1'b1 || v8 !== 1'b1 || so8 !== 3'd3) begin
            errors++; $display("FAIL mask_manual: got q=%0b v=%0b sel=%0d, expected q=1 v=1 sel=3", q8, v8, so8); end
        mask8 = 8'h00;
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0;
        din8 = '0; din6 = '0; din4 = '0; sel8 = '0; sel6 = '0; sel4 = '0;
        #12;
        checks++; if (q4 !== 8'd0 || v4 !== 1'b0 || so4 !== 2'd0 || w4 !== 1'b0 || e4 !== 1'b0) begin
            errors++; $display("FAIL init_reset: got q=%0h v=%0b sel=%0d wrap=%0b err=%0b, expected all 0", q4, v4, so4, w4, e4); end
        rst = 1'b0;
        test_reset();
        test_manual_sweep();
        test_manual_random();
        test_range_error();
        test_scan(1'b1);
        test_scan(1'b0);
        test_mode_switch();
        test_en_low();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-channel multiplexer with manual and auto-scan channel selection. It generalises the 8:1 single-bit mux to N channels of WIDTH bits each. It adds a registered output with a valid flag, an auto-scan sequencer with programmable dwell, a wrap pulse, and range-error detection. It sits between a bank of parallel sources and a single serial consumer, such as a display or monitor path.

## Interface
- WIDTH, 1, bits per channel
- N, 8, channel count (2..256)
- SELW, $clog2(N), select width
- DWELL, 1, clock cycles spent on each channel in scan mode (1..65535)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  N*WIDTH  channel k = din[k*WIDTH +: WIDTH]
- en  in  1  block enable
- mode  in  1  0 = manual, 1 = scan
- sel_in  in  SELW  manual channel select
- q  out  WIDTH  registered selected channel data
- q_valid  out  1  q holds a valid channel sample
- sel_out  out  SELW  channel that q was sampled from
- wrap  out  1  one-cycle pulse when scan moves from the last channel back to the first
- err  out  1  manual select out of range (sel_in >= N)
- ch_mask  in  N  only present with MUX_SCAN_MASK_EN; 1 = skip channel in scan

## Operation
- Reset is asynchronous and active-high. While rst = 1: q = 0, q_valid = 0, sel_out = 0, wrap = 0, err = 0, state = IDLE, dwell counter = 0, scan pointer = 0.
- State transitions are evaluated on every rising clk edge.
  - en = 0: next state IDLE. q and sel_out hold their values. q_valid = 0, wrap = 0, err = 0.
  - en = 1, mode = 0: next state MANUAL.
  - en = 1, mode = 1: next state SCAN.
- MANUAL:
  - sel_in < N: q <= din[sel_in], sel_out <= sel_in, q_valid = 1, err = 0.
  - sel_in >= N (only possible when N is not a power of 2): q and sel_out hold, q_valid = 0, err = 1.
- SCAN:
  - On entry from IDLE or MANUAL: scan pointer = 0 and dwell counter = 0. The first sample is taken from channel 0 on the entry edge.
  - Every cycle: q <= din[ptr], sel_out <= ptr, q_valid = 1. q therefore tracks live data on the current channel for the whole dwell period.
  - Dwell counter counts 0..DWELL-1. When it reaches DWELL-1 it returns to 0 and the pointer advances.
  - Pointer advances ptr+1, or from N-1 back to 0. On the N-1 to 0 advance, wrap = 1 for exactly the next cycle.
  - DWELL = 1: the channel changes every cycle.
- A mode change takes priority over the dwell count. Leaving SCAN clears wrap on the next edge.
- Channel selection and arithmetic are unsigned. The pointer compare uses N-1, not 2^SELW-1.

## Timing
- Latency is 1 cycle from din, sel_in or mode to q, sel_out, q_valid and err. No combinational path from inputs to outputs.
- A full scan cycle takes N*DWELL cycles. wrap period is N*DWELL cycles.
- If rst is asserted mid-scan, all outputs clear immediately, without waiting for a clock. After rst falls, the first edge with en = 1 and mode = 1 samples channel 0.
- en falling mid-dwell: the pointer and dwell counter freeze. Returning to SCAN restarts at channel 0. There is no resume.

## Configuration
- MUX_SCAN_MASK_EN defined:
  - The ch_mask port exists.
  - Scan skips every channel whose mask bit is 1. It advances to the next unmasked channel, wrapping as needed.
  - wrap pulses when the advance passes through index N-1 back to a lower index.
  - On SCAN entry, the pointer starts at the lowest unmasked channel.
  - All channels masked: q holds, q_valid = 0, the pointer does not move, wrap = 0.
  - MANUAL mode ignores the mask.
- MUX_SCAN_MASK_EN undefined: no ch_mask port, and every channel is scanned.

## Test plan
- Reset: assert rst asynchronously mid-cycle while en = 1. q = 0, q_valid = 0, sel_out = 0, wrap = 0 and err = 0 immediately.
- Manual sweep (N = 8, WIDTH = 1, din = 8'b0110_1101): sel_in = 0..7 in turn. On the next edge q = 1,0,1,1,0,1,1,0 and sel_out tracks sel_in with q_valid = 1.
- Range error (N = 6, SELW = 3): sel_in = 6 gives err = 1 and q_valid = 0 with q held. Then sel_in = 2 clears err.
- Scan with DWELL = 3 (N = 4, WIDTH = 8, din = {8'hDD, 8'hCC, 8'hBB, 8'hAA}): q = AA,AA,AA,BB,BB,BB,CC,... and wrap is high exactly once every 12 cycles, on the first cycle after channel 3.
- Mode switch mid-scan: from SCAN at channel 2, go to MANUAL (sel_in = 1), then back to SCAN. q = din[1], then q = din[0] on re-entry, with the dwell count restarted.
- Mask (MUX_SCAN_MASK_EN, N = 8, ch_mask = 8'b1010_1010): scan order is 0,2,4,6,0 with wrap after 6. With ch_mask = 8'hFF, q_valid = 0 and q holds.
